// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flip-flop resolve one bit
// per clock, LSB first; the result is published with a one-cycle done pulse.
module serial_adder #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] acc;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             busy_nxt, done_nxt;
    logic             load_c, step_c, finish_c;
    logic             s_bit_c, carry_nxt_c;
    logic [WIDTH-1:0] acc_sh_c;

    // Full-adder cell on the current LSBs; acc_sh_c is the partial sum after this bit.
    always_comb begin
        s_bit_c     = sa[0] ^ sb[0] ^ carry;
        carry_nxt_c = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
        acc_sh_c    = {s_bit_c, acc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        load_c    = 1'b0;
        step_c    = 1'b0;
        finish_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    busy_nxt  = 1'b1;
                    load_c    = 1'b1;
                end
            end
            S_RUN: begin
                step_c = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                    finish_c  = 1'b1;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand shifters, carry, partial sum and the published result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (load_c) begin
            sa    <= a;
            sb    <= b;
            acc   <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (step_c) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            acc   <= acc_sh_c[WIDTH-1:1];
            carry <= carry_nxt_c;
            cnt   <= cnt + CNT_W'(1);
            if (finish_c) begin
                sum  <= acc_sh_c;
                cout <= carry_nxt_c;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three widths (2, 8, 32) run against a timeline model
// that predicts busy/done/sum/cout from a + b + cin each cycle.
module tb_serial_adder;

    localparam int NL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start2 = 1'b0, start8 = 1'b0, start32 = 1'b0;
    logic [1:0]  a2 = '0, b2 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        cin2 = 1'b0, cin8 = 1'b0, cin32 = 1'b0;
    logic        busy2, busy8, busy32, done2, done8, done32;
    logic        cout2, cout8, cout32;
    logic [1:0]  sum2;
    logic [7:0]  sum8;
    logic [31:0] sum32;

    serial_adder #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2));
    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
    serial_adder #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32));

    logic        start_v[NL], cin_v[NL], busy_v[NL], done_v[NL], cout_v[NL];
    logic [31:0] a_v[NL], b_v[NL], sum_v[NL];

    assign start_v[0] = start2;  assign start_v[1] = start8;  assign start_v[2] = start32;
    assign cin_v[0]   = cin2;    assign cin_v[1]   = cin8;    assign cin_v[2]   = cin32;
    assign a_v[0] = 32'(a2);     assign a_v[1] = 32'(a8);     assign a_v[2] = a32;
    assign b_v[0] = 32'(b2);     assign b_v[1] = 32'(b8);     assign b_v[2] = b32;
    assign busy_v[0] = busy2;    assign busy_v[1] = busy8;    assign busy_v[2] = busy32;
    assign done_v[0] = done2;    assign done_v[1] = done8;    assign done_v[2] = done32;
    assign sum_v[0] = 32'(sum2); assign sum_v[1] = 32'(sum8); assign sum_v[2] = sum32;
    assign cout_v[0] = cout2;    assign cout_v[1] = cout8;    assign cout_v[2] = cout32;

    function automatic int lw(input int l);
        return (l == 0) ? 2 : ((l == 1) ? 8 : 32);
    endfunction

    // Model: k = edges since the accepted start (0 = idle); result is a+b+cin.
    int          k[NL]        = '{default: 0};
    logic [31:0] ea[NL]       = '{default: '0};
    logic [31:0] eb[NL]       = '{default: '0};
    logic        ec[NL]       = '{default: 1'b0};
    logic [31:0] exp_sum[NL]  = '{default: '0};
    logic        exp_cout[NL] = '{default: 1'b0};

    always @(posedge clk or negedge rst_n) begin
        logic [63:0] tot;
        logic [63:0] mask;
        if (!rst_n) begin
            for (int l = 0; l < NL; l++) begin
                k[l]        <= 0;
                exp_sum[l]  <= '0;
                exp_cout[l] <= 1'b0;
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                if (k[l] == 0) begin
                    if (start_v[l] === 1'b1) begin
                        ea[l] <= a_v[l];
                        eb[l] <= b_v[l];
                        ec[l] <= cin_v[l];
                        k[l]  <= 1;
                    end
                end else if (k[l] == lw(l) + 1) begin
                    k[l] <= 0;
                end else begin
                    k[l] <= k[l] + 1;
                    if (k[l] + 1 == lw(l) + 1) begin
                        tot  = 64'(ea[l]) + 64'(eb[l]) + 64'(ec[l]);
                        mask = (64'd1 << lw(l)) - 64'd1;
                        exp_sum[l]  <= 32'(tot & mask);
                        exp_cout[l] <= tot[lw(l)];
                    end
                end
            end
        end
    end

    // Hand-computed expectations for directed operations.
    logic        lit_valid[NL] = '{default: 1'b0};
    logic [31:0] lit_sum[NL]   = '{default: '0};
    logic        lit_cout[NL]  = '{default: 1'b0};

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input int l, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s W%0d t=%0t: got %0h expected %0h", nm, lw(l), $time, act, expv);
        end
    endtask

    // Compare process: every falling clock edge and just after any reset assertion.
    always begin
        @(negedge clk or negedge rst_n);
        #1;
        for (int l = 0; l < NL; l++) begin
            check("busy", l, 32'(busy_v[l]), 32'(k[l] >= 1 && k[l] <= lw(l)));
            check("done", l, 32'(done_v[l]), 32'(k[l] == lw(l) + 1));
            check("sum",  l, sum_v[l], exp_sum[l]);
            check("cout", l, 32'(cout_v[l]), 32'(exp_cout[l]));
            if (lit_valid[l] && k[l] == lw(l) + 1) begin
                check("lit_sum",  l, sum_v[l], lit_sum[l]);
                check("lit_cout", l, 32'(cout_v[l]), 32'(lit_cout[l]));
            end
        end
    end

    task automatic set_in(input int l, input logic s, input logic [31:0] a, input logic [31:0] b, input logic c);
        case (l)
            0: begin start2 = s; a2 = a[1:0]; b2 = b[1:0]; cin2 = c; end
            1: begin start8 = s; a8 = a[7:0]; b8 = b[7:0]; cin8 = c; end
            default: begin start32 = s; a32 = a; b32 = b; cin32 = c; end
        endcase
    endtask

    task automatic do_op(input int l, input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic [31:0] ls, input logic lc);
        lit_sum[l]   = ls;
        lit_cout[l]  = lc;
        lit_valid[l] = 1'b1;
        @(negedge clk);
        set_in(l, 1'b1, a, b, c);
        @(negedge clk);
        set_in(l, 1'b0, $urandom, $urandom, 1'(($urandom)));
        repeat (lw(l) + 2) @(negedge clk);
        lit_valid[l] = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_op(1, 32'h5A, 32'h3C, 1'b0, 32'h96, 1'b0);
        do_op(1, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1);
        do_op(1, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1);
        do_op(1, 32'h00, 32'h00, 1'b1, 32'h01, 1'b0);
        do_op(0, 32'h3, 32'h3, 1'b1, 32'h3, 1'b1);
        do_op(2, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1);

        // Start held high with operands changing every cycle.
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            set_in(1, 1'b1, $urandom, $urandom, 1'($urandom));
        end
        @(negedge clk);
        set_in(1, 1'b0, 0, 0, 1'b0);
        repeat (12) @(negedge clk);

        // Asynchronous reset four bits into AA+55.
        set_in(1, 1'b1, 32'hAA, 32'h55, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_in(1, 1'b0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(1, 32'hAA, 32'h55, 1'b0, 32'hFF, 1'b0);

        // Random traffic on all widths, with occasional all-ones operands.
        for (int i = 0; i < 11000; i++) begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                if ($urandom_range(7) == 0)
                    set_in(l, 1'b1, 32'hFFFFFFFF, $urandom, 1'($urandom));
                else
                    set_in(l, ($urandom_range(3) != 0), $urandom, $urandom, 1'($urandom));
            end
        end
        for (int l = 0; l < NL; l++) set_in(l, 1'b0, 0, 0, 1'b0);
        repeat (40) @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
